// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the cache/main-memory arbiter and its fill sequencer.
package mem_arb_pkg;
  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 16;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int MEM_LATENCY     = 4;
  localparam int BLK_OFFSET_W    = 4;
  localparam int CNT_W           = 4;   // counts 0..WORDS_PER_BLOCK inclusive
  localparam int IDX_W           = 3;

  typedef enum logic [1:0] {IDLE, WRITE, FILL_I, FILL_D} arb_state_e;

  // Request vector bit positions; higher bit wins.
  localparam logic [2:0] PRIO_WR    = 3'b100;
  localparam logic [2:0] PRIO_DMISS = 3'b010;
  localparam logic [2:0] PRIO_IMISS = 3'b001;

  function automatic arb_state_e arb_pick(input logic [2:0] req);
    if ((req & PRIO_WR) != 3'b000)         return WRITE;
    else if ((req & PRIO_DMISS) != 3'b000) return FILL_D;
    else if ((req & PRIO_IMISS) != 3'b000) return FILL_I;
    else                                   return IDLE;
  endfunction
endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache-side request/fill signals and the main-memory port, grouped for the arbiter.
interface cache_mem_arbiter_if;
  import mem_arb_pkg::*;

  logic              i_miss_req;
  logic [ADDR_W-1:0] i_miss_addr;
  logic              i_fill_valid;
  logic [IDX_W-1:0]  i_fill_idx;
  logic [DATA_W-1:0] i_fill_data;
  logic              i_fill_done;
  logic              d_miss_req;
  logic [ADDR_W-1:0] d_miss_addr;
  logic              d_fill_valid;
  logic [IDX_W-1:0]  d_fill_idx;
  logic [DATA_W-1:0] d_fill_data;
  logic              d_fill_done;
  logic              d_wr_req;
  logic [ADDR_W-1:0] d_wr_addr;
  logic [DATA_W-1:0] d_wr_data;
  logic              d_wr_ack;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_data_valid;
  logic              busy;

  modport master (
    input  i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
           d_wr_req, d_wr_addr, d_wr_data, mem_rdata, mem_data_valid,
    output i_fill_valid, i_fill_idx, i_fill_data, i_fill_done,
           d_fill_valid, d_fill_idx, d_fill_data, d_fill_done,
           d_wr_ack, mem_en, mem_wr, mem_addr, mem_wdata, busy
  );

  modport slave (
    output i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
           d_wr_req, d_wr_addr, d_wr_data, mem_rdata, mem_data_valid,
    input  i_fill_valid, i_fill_idx, i_fill_data, i_fill_done,
           d_fill_valid, d_fill_idx, d_fill_data, d_fill_done,
           d_wr_ack, mem_en, mem_wr, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/cache_mem_arbiter_fill_seq.sv
// Block-fill sequencer: issues one read per word, counts returns, flags the last word.
module blk_fill_seq
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              active_i,
  input  logic [ADDR_W-1:0] blk_addr_i,
  input  logic              data_valid_i,
  output logic              issue_o,
  output logic [ADDR_W-1:0] issue_addr_o,
  output logic              recv_o,
  output logic [IDX_W-1:0]  recv_idx_o,
  output logic              done_o
);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_BLOCK - 1);

  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] recv_cnt_q, recv_cnt_d;

  always_comb begin
    issue_o      = active_i && (issue_cnt_q < CNT_FULL);
    recv_o       = active_i && data_valid_i && (recv_cnt_q < CNT_FULL);
    done_o       = recv_o && (recv_cnt_q == CNT_LAST);
    recv_idx_o   = recv_o ? recv_cnt_q[IDX_W-1:0] : '0;
    // Word offset is spliced in from the counter so no carry can reach the block bits.
    issue_addr_o = issue_o ? {blk_addr_i[ADDR_W-1:BLK_OFFSET_W], issue_cnt_q[IDX_W-1:0], 1'b0} : '0;

    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    if (clr_i) begin
      issue_cnt_d = '0;
      recv_cnt_d  = '0;
    end else begin
      if (issue_o) issue_cnt_d = issue_cnt_q + 1'b1;
      if (recv_o)  recv_cnt_d  = recv_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end
endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-cache fills, D-cache fills and D-cache write-through stores onto one memory port.
module cache_mem_arbiter
  import mem_arb_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  cache_mem_arbiter_if.master bus
);
  arb_state_e        state_q;
  arb_state_e        pick;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              grant;
  logic              filling;
  logic              seq_issue, seq_recv, seq_done;
  logic [ADDR_W-1:0] seq_addr;
  logic [IDX_W-1:0]  seq_idx;

  assign pick    = arb_pick({bus.d_wr_req, bus.d_miss_req, bus.i_miss_req});
  assign grant   = (state_q == IDLE) && (pick != IDLE);
  assign filling = (state_q == FILL_I) || (state_q == FILL_D);

  blk_fill_seq u_seq (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (grant),
    .active_i     (filling),
    .blk_addr_i   (addr_q),
    .data_valid_i (bus.mem_data_valid),
    .issue_o      (seq_issue),
    .issue_addr_o (seq_addr),
    .recv_o       (seq_recv),
    .recv_idx_o   (seq_idx),
    .done_o       (seq_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= pick;
          case (pick)
            WRITE: begin
              addr_q  <= bus.d_wr_addr;
              wdata_q <= bus.d_wr_data;
            end
            FILL_D:  addr_q <= bus.d_miss_addr;
            FILL_I:  addr_q <= bus.i_miss_addr;
            default: ;
          endcase
        end
        WRITE:          state_q <= IDLE;
        FILL_I, FILL_D: if (seq_done) state_q <= IDLE;
        default:        state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.d_wr_ack  = (state_q == WRITE);
    bus.mem_en    = (state_q == WRITE) || seq_issue;
    bus.mem_wr    = (state_q == WRITE);
    bus.mem_addr  = (state_q == WRITE) ? addr_q : seq_addr;
    bus.mem_wdata = (state_q == WRITE) ? wdata_q : '0;

    // Only the owning side sees valid/idx/done; data is a shared mirror.
    bus.i_fill_valid = (state_q == FILL_I) && seq_recv;
    bus.i_fill_idx   = (state_q == FILL_I) ? seq_idx : '0;
    bus.i_fill_done  = (state_q == FILL_I) && seq_done;
    bus.d_fill_valid = (state_q == FILL_D) && seq_recv;
    bus.d_fill_idx   = (state_q == FILL_D) ? seq_idx : '0;
    bus.d_fill_done  = (state_q == FILL_D) && seq_done;
    bus.i_fill_data  = bus.mem_rdata;
    bus.d_fill_data  = bus.mem_rdata;
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with a 4-cycle pipelined memory model and stall injection.
module tb_cache_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_mem_arbiter_if mif ();
  cache_mem_arbiter dut (.clk(clk), .rst(rst), .bus(mif));

  int n_chk  = 0;
  int n_pass = 0;

  // Memory model: a read issued in cycle c returns in cycle c+4 unless held.
  typedef struct { logic [15:0] a; int rdy; } ent_t;
  ent_t        q[$];
  int          cyc    = 0;
  logic        hold   = 1'b0;
  logic        m_dv   = 1'b0;
  logic [15:0] m_rd   = '0;
  logic        man_en = 1'b0;
  logic        man_dv = 1'b0;
  logic [15:0] man_rd = '0;

  assign mif.mem_data_valid = man_en ? man_dv : m_dv;
  assign mif.mem_rdata      = man_en ? man_rd : m_rd;

  always @(posedge clk) begin
    if (m_dv && q.size() > 0) q.delete(0);
    if (mif.mem_en && !mif.mem_wr && !man_en) q.push_back('{mif.mem_addr, cyc + 4});
    cyc++;
    #1;
    if (q.size() > 0 && q[0].rdy <= cyc && !hold) begin
      m_dv = 1'b1;
      m_rd = q[0].a ^ 16'h5A5A;
    end else begin
      m_dv = 1'b0;
      m_rd = '0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  // Follows one fill granted at the edge just before the first cycle; optional hold window.
  task automatic do_fill(input bit is_d, input logic [15:0] addr, input int gap_s, input int gap_n);
    logic [15:0] base;
    int          k;
    bit          done_seen;
    logic        own_v, oth_v, own_dn;
    logic [2:0]  own_ix;
    logic [15:0] own_dt;
    bit          exp_v;
    base = addr & 16'hFFF0;
    k = 0;
    done_seen = 0;
    for (int c = 1; c <= 40 && !done_seen; c++) begin
      nxt();
      own_v  = is_d ? mif.d_fill_valid : mif.i_fill_valid;
      oth_v  = is_d ? mif.i_fill_valid : mif.d_fill_valid;
      own_dn = is_d ? mif.d_fill_done  : mif.i_fill_done;
      own_ix = is_d ? mif.d_fill_idx   : mif.i_fill_idx;
      own_dt = is_d ? mif.d_fill_data  : mif.i_fill_data;
      chk("fill_busy", mif.busy, 1);
      chk("fill_mem_en", mif.mem_en, (c <= 8));
      if (c <= 8) begin
        chk("rd_addr", mif.mem_addr, base | 16'((c - 1) << 1));
        chk("rd_wr", mif.mem_wr, 0);
      end
      exp_v = !hold && (k < 8) && (c >= k + 5);
      chk("own_valid", own_v, exp_v);
      chk("other_valid", oth_v, 0);
      if (exp_v) begin
        chk("fill_idx", own_ix, k);
        chk("fill_data", own_dt, (base | 16'(k << 1)) ^ 16'h5A5A);
        chk("fill_done", own_dn, (k == 7));
        if (k == 7) done_seen = 1;
        k++;
      end else begin
        chk("no_done", own_dn, 0);
      end
      hold = (c + 1 >= gap_s) && (c + 1 < gap_s + gap_n);
    end
    hold = 1'b0;
    chk("fill_finished", done_seen, 1);
    if (is_d) mif.d_miss_req = 1'b0;
    else      mif.i_miss_req = 1'b0;
    nxt();
    chk("post_fill_idle", mif.busy, 0);
    chk("post_fill_valid", is_d ? mif.d_fill_valid : mif.i_fill_valid, 0);
  endtask

  initial begin
    int cnt;
    int done_c;
    mif.i_miss_req  = 1'b0;
    mif.i_miss_addr = '0;
    mif.d_miss_req  = 1'b0;
    mif.d_miss_addr = '0;
    mif.d_wr_req    = 1'b0;
    mif.d_wr_addr   = '0;
    mif.d_wr_data   = '0;

    // Reset state
    #3;
    chk("rst_busy", mif.busy, 0);
    chk("rst_mem_en", mif.mem_en, 0);
    chk("rst_mem_wr", mif.mem_wr, 0);
    chk("rst_mem_addr", mif.mem_addr, 0);
    chk("rst_mem_wdata", mif.mem_wdata, 0);
    chk("rst_ack", mif.d_wr_ack, 0);
    chk("rst_ivalid", mif.i_fill_valid, 0);
    chk("rst_dvalid", mif.d_fill_valid, 0);
    chk("rst_idone", mif.i_fill_done, 0);
    chk("rst_ddone", mif.d_fill_done, 0);
    chk("rst_idata", mif.i_fill_data, 0);
    nxt();
    nxt();
    rst = 1'b0;
    nxt();

    // Single I miss
    mif.i_miss_req  = 1'b1;
    mif.i_miss_addr = 16'h1234;
    do_fill(0, 16'h1234, 100, 0);

    // Simultaneous D and I misses: D first, I immediately after
    mif.d_miss_req  = 1'b1;
    mif.d_miss_addr = 16'h0040;
    mif.i_miss_req  = 1'b1;
    mif.i_miss_addr = 16'h2000;
    do_fill(1, 16'h0040, 100, 0);
    chk("i_still_pending", mif.i_miss_req, 1);
    do_fill(0, 16'h2000, 100, 0);

    // Store beats a held D miss
    mif.d_wr_req    = 1'b1;
    mif.d_wr_addr   = 16'h00A4;
    mif.d_wr_data   = 16'hBEEF;
    mif.d_miss_req  = 1'b1;
    mif.d_miss_addr = 16'h0080;
    nxt();
    chk("wr_en", mif.mem_en, 1);
    chk("wr_wr", mif.mem_wr, 1);
    chk("wr_addr", mif.mem_addr, 16'h00A4);
    chk("wr_data", mif.mem_wdata, 16'hBEEF);
    chk("wr_ack", mif.d_wr_ack, 1);
    mif.d_wr_req = 1'b0;
    nxt();
    chk("wr_idle", mif.busy, 0);
    chk("wr_ack_pulse", mif.d_wr_ack, 0);
    chk("wr_en_off", mif.mem_en, 0);
    do_fill(1, 16'h0080, 100, 0);

    // Three-cycle return gap mid-fill
    mif.i_miss_req  = 1'b1;
    mif.i_miss_addr = 16'h0A06;
    do_fill(0, 16'h0A06, 7, 3);

    // Reset in cycle 6 of a fill
    mif.i_miss_req  = 1'b1;
    mif.i_miss_addr = 16'h3000;
    for (int c = 1; c <= 5; c++) nxt();
    mif.i_miss_req = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", mif.busy, 0);
    chk("mid_rst_en", mif.mem_en, 0);
    chk("mid_rst_addr", mif.mem_addr, 0);
    chk("mid_rst_ivalid", mif.i_fill_valid, 0);
    chk("mid_rst_idone", mif.i_fill_done, 0);
    chk("mid_rst_iidx", mif.i_fill_idx, 0);
    nxt();
    nxt();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      nxt();
      chk("stale_ivalid", mif.i_fill_valid, 0);
      chk("stale_dvalid", mif.d_fill_valid, 0);
      chk("stale_busy", mif.busy, 0);
    end
    mif.i_miss_req  = 1'b1;
    mif.i_miss_addr = 16'h4567;
    do_fill(0, 16'h4567, 100, 0);

    // Ten returns for one fill: only eight are forwarded
    man_en          = 1'b1;
    mif.i_miss_req  = 1'b1;
    mif.i_miss_addr = 16'h5000;
    cnt    = 0;
    done_c = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      man_dv = (c >= 2 && c <= 11);
      man_rd = 16'h0100 + 16'(c);
      @(negedge clk);
      if (c >= 10) chk("extra_ignored", mif.i_fill_valid, 0);
      if (c == 10) chk("extra_idle", mif.busy, 0);
      if (mif.i_fill_valid) begin
        chk("extra_idx", mif.i_fill_idx, cnt);
        if (mif.i_fill_done) begin
          done_c = c;
          mif.i_miss_req = 1'b0;
        end
        cnt++;
      end
    end
    chk("extra_count", cnt, 8);
    chk("extra_done_cycle", done_c, 9);
    man_dv = 1'b0;
    man_en = 1'b0;
    nxt();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
